// File: rtl/tl_ad_buffer_pkg.sv
// Shared TileLink A/D field widths, opcodes, packing offsets and width helpers
// for the tl_ad_buffer block.
package tl_ad_buffer_pkg;

  localparam logic [2:0] OP_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_A_GET             = 3'd4;
  localparam logic [2:0] OP_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_D_ACCESS_ACK_DATA = 3'd1;

  localparam int OPCODE_W  = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 3;
  localparam int CORRUPT_W = 1;
  localparam int DENIED_W  = 1;

  // Offsets from the LSB; packing is MSB-first so corrupt sits at bit 0.
  localparam int CORRUPT_OFF = 0;
  localparam int DATA_OFF    = CORRUPT_OFF + CORRUPT_W;

  function automatic int a_width(input int addr_w, input int data_w, input int source_w);
    return OPCODE_W + A_PARAM_W + SIZE_W + source_w + addr_w + data_w / 8 + data_w + CORRUPT_W;
  endfunction

  function automatic int d_width(input int data_w, input int source_w);
    return OPCODE_W + D_PARAM_W + SIZE_W + source_w + DENIED_W + data_w + CORRUPT_W;
  endfunction

  function automatic int a_mask_off(input int data_w);
    return DATA_OFF + data_w;
  endfunction

  function automatic int a_addr_off(input int data_w);
    return a_mask_off(data_w) + data_w / 8;
  endfunction

  function automatic int a_source_off(input int addr_w, input int data_w);
    return a_addr_off(data_w) + addr_w;
  endfunction

  function automatic int d_denied_off(input int data_w);
    return DATA_OFF + data_w;
  endfunction

  function automatic int d_source_off(input int data_w);
    return d_denied_off(data_w) + DENIED_W;
  endfunction

  // A depth-0 queue still exposes a one-bit count tied to zero.
  function automatic int cnt_width(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_ad_queue.sv
// Generic ready/valid FIFO; DEPTH=0 is a combinational wire. Optional macro
// TL_AD_BUFFER_FLOW_EN forwards input to output combinationally when empty.
module tl_ad_queue
  import tl_ad_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [CNT_W-1:0] count
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_bits  = in_bits;
    assign count     = '0;
  end else begin : g_fifo
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty, pass, enq, deq;

    assign empty = (cnt_q == '0);
`ifdef TL_AD_BUFFER_FLOW_EN
    assign pass = empty & in_valid;
`else
    assign pass = 1'b0;
`endif
    // No bypass when full: in_ready depends only on registered count.
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign out_valid = ~empty | pass;
    assign out_bits  = pass ? in_bits : mem_q[rd_q];
    assign deq       = out_ready & ~empty;
    assign enq       = in_valid & in_ready & ~(pass & out_ready);

    always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (enq) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (deq) rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clock) begin
      if (enq && !reset) mem_q[wr_q] <= in_bits;
    end

    assign count = cnt_q;
  end

endmodule

// File: rtl/tl_ad_buffer.sv
// Two independent TileLink channel buffers (A: client->manager, D: manager->client)
// with occupancy and idle reporting. Macro TL_AD_BUFFER_FLOW_EN enables flow mode.
module tl_ad_buffer
  import tl_ad_buffer_pkg::*;
#(
  parameter int ADDR_W   = 31,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 7,
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  localparam int A_W     = a_width(ADDR_W, DATA_W, SOURCE_W),
  localparam int D_W     = d_width(DATA_W, SOURCE_W),
  localparam int A_CNT_W = cnt_width(A_DEPTH),
  localparam int D_CNT_W = cnt_width(D_DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_in_valid,
  output logic               a_in_ready,
  input  logic [A_W-1:0]     a_in_bits,
  output logic               a_out_valid,
  input  logic               a_out_ready,
  output logic [A_W-1:0]     a_out_bits,
  input  logic               d_in_valid,
  output logic               d_in_ready,
  input  logic [D_W-1:0]     d_in_bits,
  output logic               d_out_valid,
  input  logic               d_out_ready,
  output logic [D_W-1:0]     d_out_bits,
  output logic [A_CNT_W-1:0] a_count,
  output logic [D_CNT_W-1:0] d_count,
  output logic               idle
);

  tl_ad_queue #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_bits   (a_in_bits),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_bits  (a_out_bits),
    .count     (a_count)
  );

  tl_ad_queue #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_bits   (d_in_bits),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_bits  (d_out_bits),
    .count     (d_count)
  );

  assign idle = (a_count == '0) && (d_count == '0);

endmodule
